// File: rtl/rd_arbiter_if.sv
// Requester/sequencer-side bus for rd_arbiter: requests, grants and completion,
// plus the go/ds strobe pair to the shared read sequencer.
interface rd_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         go;
  logic         ds;
  logic         busy;
  logic         timeout_err;

  modport master (
    output req, ds,
    input  gnt, done, go, busy, timeout_err
  );

  modport slave (
    input  req, ds,
    output gnt, done, go, busy, timeout_err
  );
endinterface

// File: rtl/rd_arbiter.sv
// Round-robin arbiter sharing one wait-state read sequencer between N requesters,
// with a watchdog that aborts a transaction when ds never arrives.
module rd_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 8
) (
  input  logic         clock,
  input  logic         reset,
  rd_arbiter_if.slave  bus
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LAST_RST = LW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LW-1:0]  last_q, last_d;
  logic [LW-1:0]  win_q, win_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   done_q, done_d;
  logic           go_q, go_d;
  logic           busy_q, busy_d;
  logic           terr_q, terr_d;
  logic [LW-1:0]  pick;

  // First set bit of r scanning upward from last+1, wrapping modulo N.
  function automatic logic [LW-1:0] rr_pick(input logic [N-1:0] r,
                                            input logic [LW-1:0] last);
    logic          found;
    logic [LW-1:0] idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last) + k) % N);
      if (!found && r[idx]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

  assign pick = rr_pick(bus.req, last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    go_d    = 1'b0;
    terr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          win_d       = pick;
          go_d        = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // ds takes precedence over a watchdog expiry in the same cycle.
        if (bus.ds) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          last_d  = win_q;
          state_d = ST_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          gnt_d   = '0;
          last_d  = win_q;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.go          = go_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_rd_arbiter.sv
// Directed bench for rd_arbiter (N=4, TIMEOUT=8): fairness, wrap, watchdog,
// ds/timeout race, stray ds and asynchronous reset.
module tb_rd_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  rd_arbiter_if #(.N(4)) bus();

  rd_arbiter #(.N(4), .TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle_outs(input string tag);
    chk4({tag, "_gnt"},  bus.gnt,         4'b0000);
    chk4({tag, "_done"}, bus.done,        4'b0000);
    chk1({tag, "_go"},   bus.go,          1'b0);
    chk1({tag, "_busy"}, bus.busy,        1'b0);
    chk1({tag, "_terr"}, bus.timeout_err, 1'b0);
  endtask

  // One full transaction from the IDLE sampling edge to the cycle after RELEASE.
  // ds_at is the 1-based WAIT cycle in which ds is high; 0 means never.
  task automatic txn(input logic [3:0] r, input logic [3:0] eg, input int ds_at,
                     input string tag);
    bus.req = r;
    tick();
    chk4({tag, "_gnt"},  bus.gnt,  eg);
    chk1({tag, "_go"},   bus.go,   1'b1);
    chk1({tag, "_busy"}, bus.busy, 1'b1);
    tick();
    chk1({tag, "_go_low"},   bus.go,  1'b0);
    chk4({tag, "_gnt_held"}, bus.gnt, eg);
    for (int w = 1; w <= 8; w++) begin
      bus.ds = (w == ds_at);
      tick();
      bus.ds = 1'b0;
      if (w == ds_at) break;
      if (w < 8) begin
        chk4({tag, "_wait_gnt"},  bus.gnt,         eg);
        chk1({tag, "_wait_terr"}, bus.timeout_err, 1'b0);
        chk4({tag, "_wait_done"}, bus.done,        4'b0000);
      end
    end
    if (ds_at >= 1 && ds_at <= 8) begin
      chk4({tag, "_done"}, bus.done,        eg);
      chk1({tag, "_terr"}, bus.timeout_err, 1'b0);
    end else begin
      chk4({tag, "_done"}, bus.done,        4'b0000);
      chk1({tag, "_terr"}, bus.timeout_err, 1'b1);
    end
    chk4({tag, "_rel_gnt"},  bus.gnt,  4'b0000);
    chk1({tag, "_rel_busy"}, bus.busy, 1'b1);
    tick();
    chk4({tag, "_end_done"}, bus.done,        4'b0000);
    chk1({tag, "_end_terr"}, bus.timeout_err, 1'b0);
    chk1({tag, "_end_busy"}, bus.busy,        1'b0);
  endtask

  // Structural invariants, sampled away from the active edge.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      vectors++;
      assert ($onehot0(bus.gnt) && !((bus.done != 4'b0000) && bus.timeout_err)
              && ((bus.gnt == 4'b0000) || bus.busy)) else begin
        miscompares++;
        $error("FAIL invariant: observed gnt=%b done=%b terr=%b busy=%b expected onehot0 gnt, exclusive done/terr, busy with gnt",
               bus.gnt, bus.done, bus.timeout_err, bus.busy);
      end
    end
  end

  initial begin
    logic [3:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req = 4'b0000;
    bus.ds  = 1'b0;
    tick();
    tick();
    idle_outs("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) txn(4'b1111, rr_exp[i], 1, "rr");
    bus.req = 4'b0000;
    tick();
    idle_outs("rr_idle");

    txn(4'b0001, 4'b0001, 3, "single");

    txn(4'b0100, 4'b0100, 1, "setup_last2");
    txn(4'b0011, 4'b0001, 1, "skip_to0");
    txn(4'b0011, 4'b0010, 1, "then1");
    txn(4'b1000, 4'b1000, 2, "only3");
    txn(4'b0001, 4'b0001, 1, "wrap0");

    txn(4'b0100, 4'b0100, 0, "timeout");
    txn(4'b1111, 4'b1000, 1, "after_timeout");

    txn(4'b0100, 4'b0100, 8, "ds_at_limit");

    bus.req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      bus.ds = 1'b1;
      tick();
      idle_outs("stray_ds");
    end
    bus.ds = 1'b0;
    txn(4'b1111, 4'b1000, 1, "ptr_after_stray");

    bus.req = 4'b0001;
    tick();
    tick();
    tick();
    chk4("pre_reset_gnt", bus.gnt, 4'b0001);
    #2;
    reset = 1'b1;
    #1;
    idle_outs("async_reset");
    @(negedge clock);
    reset = 1'b0;
    txn(4'b0010, 4'b0010, 1, "post_reset");
    bus.req = 4'b0000;
    tick();
    idle_outs("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rd_arbiter.md
Name: rd_arbiter

Overview:
- Round-robin arbiter that shares one wait-state read sequencer between N requesters.
- The sequencer has a go input and a ds (data strobe / done) output.
- Block grants one requester at a time, pulses go for one cycle, waits for ds, then returns done to the winner.
- Includes a watchdog that aborts a transaction if ds never arrives.

Parameters:
- N, 4, number of requesters (2..8)
- TIMEOUT, 8, maximum WAIT cycles allowed for ds before abort (>=2)

Ports:
- clock  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- req  input  N  per-requester request level; bit i = requester i
- gnt  output  N  one-hot grant, held for the whole transaction
- done  output  N  one-cycle pulse to the winner on successful completion
- go  output  1  start strobe to the read sequencer, one cycle wide
- ds  input  1  completion strobe from the read sequencer
- busy  output  1  high whenever state != IDLE
- timeout_err  output  1  one-cycle pulse when a transaction is aborted

Behaviour:
- Reset (async, active-high) clears all outputs and forces the following:
  - gnt=0, done=0, go=0, busy=0, timeout_err=0
  - state=IDLE, wait counter=0
  - priority pointer last=N-1, so requester 0 has first priority
- All outputs are registered. There is no combinational path from req or ds to any output.
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner: the first set bit of req scanning from last+1 upward, wrapping modulo N.
  - At the edge: gnt<=onehot(winner), go<=1, state<=ISSUE.
- ISSUE (exactly 1 cycle): go<=0, counter<=0, state<=WAIT. gnt stays held.
- WAIT:
  - If ds=1: done<=gnt, gnt<=0, last<=winner index, state<=RELEASE.
  - Else if counter==TIMEOUT-1: timeout_err<=1, gnt<=0, done stays 0, last<=winner index, state<=RELEASE.
  - Else counter<=counter+1.
  - If ds arrives on the same cycle the timeout fires, ds wins: normal completion, no error.
- RELEASE (exactly 1 cycle):
  - done/timeout_err pulse is visible this cycle and cleared at the next edge.
  - state<=IDLE.
  - req is not sampled in RELEASE.
- Latency:
  - req sampled in IDLE at edge k gives gnt and go high in cycle k+1.
  - ds sampled high at edge m gives done high in cycle m+1.
  - Minimum gap between consecutive grants is 1 idle cycle (RELEASE), plus the IDLE sampling edge.
- Requester rules:
  - A requester should drop req on seeing done.
  - A req held high is re-arbitrated normally. Because last now points at it, every other active requester gets a grant first.
  - Dropping req while granted does not cancel the transaction.
- Stray ds in IDLE, ISSUE or RELEASE is ignored and has no side effects.
- Counter width is clog2(TIMEOUT). It never wraps, because it is reset in ISSUE.
- Invariants:
  - gnt is zero or one-hot at all times.
  - gnt!=0 implies busy=1.
  - done and timeout_err are never high together.

Test Plan:
- Reset mid-WAIT: assert reset asynchronously between edges → all outputs 0 immediately. After release, req=4'b0010 grants gnt=4'b0010 (pointer back to N-1).
- Single requester: req=4'b0001 → gnt=0001 and go=1 for one cycle. ds pulsed in 3rd WAIT cycle → done=0001 for one cycle, then busy=0.
- Round-robin fairness: req=4'b1111 held, ds returned after 1 WAIT cycle each time → grant order 0,1,2,3,0. Each gnt is one-hot, go is one pulse per grant.
- Skip and wrap: last=2, req=4'b0011 → grant 0 next, then 1. With req=4'b1000 only → grant 3, then wraps to 0 if req=4'b0001.
- Timeout: TIMEOUT=8, req=4'b0100, ds never asserted → after 8 WAIT cycles timeout_err=1 for one cycle, done=0, gnt=0. Next grant goes to the next requester after 2.
- ds coincident with last timeout cycle (WAIT cycle 8) → done=0100, timeout_err stays 0. Stray ds in IDLE → no outputs change.
